// File: rtl/ce_ls_rs_rx_if.sv
// rtl/ce_ls_rs_rx_if.sv - sample sink, estimate source and reference ROM port bundle for ce_ls_rs_rx
interface ce_ls_rs_rx_if #(
    parameter int wDataIn  = 18,
    parameter int wDataOut = 18
);
    logic                       sink_valid;
    logic                       sink_sop;
    logic                       sink_eop;
    logic signed [wDataIn-1:0]  sink_real;
    logic signed [wDataIn-1:0]  sink_imag;
    logic [11:0]                fftpts_in;
    logic                       source_valid;
    logic                       source_sop;
    logic                       source_eop;
    logic signed [wDataOut-1:0] source_real;
    logic signed [wDataOut-1:0] source_imag;
    logic                       err_len;
    logic                       err_sop;
    // Local ZC reference ROM (ROM_RS_tx_UE0_real/imag), one-clock read latency
    logic [10:0]                rom_addr;
    logic signed [wDataOut-1:0] rom_real;
    logic signed [wDataOut-1:0] rom_imag;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
        output rom_real, rom_imag,
        input  source_valid, source_sop, source_eop, source_real, source_imag,
        input  err_len, err_sop, rom_addr
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
        input  rom_real, rom_imag,
        output source_valid, source_sop, source_eop, source_real, source_imag,
        output err_len, err_sop, rom_addr
    );
endinterface

// File: rtl/ce_ls_rs_rx.sv
// rtl/ce_ls_rs_rx.sv - LS channel estimate H = Y*conj(X) >> 16; optional clamp via CE_LS_RS_RX_SAT_EN
module ce_ls_rs_rx #(
    parameter int wDataIn  = 18,
    parameter int wDataOut = 18
) (
    input  logic          clk,
    input  logic          rst_n_sync,
    ce_ls_rs_rx_if.slave  bus
);
    localparam int wP = wDataIn + wDataOut;
    localparam int wS = wP + 1;
    localparam int wH = wS - 16;
    localparam logic [wS-1:0]       RND  = wS'(32768);
    localparam logic [wDataOut-1:0] MAXV = {1'b0, {(wDataOut-1){1'b1}}};
    localparam logic [wDataOut-1:0] MINV = {1'b1, {(wDataOut-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [wDataOut-1:0] fit(input logic [wS-1:0] s);
`ifdef CE_LS_RS_RX_SAT_EN
        logic [wH-1:0] h;
        h = wH'((s + RND) >> 16);
        if (!(&h[wH-1:wDataOut-1]) && (|h[wH-1:wDataOut-1]))
            return h[wH-1] ? MINV : MAXV;
        return h[wDataOut-1:0];
`else
        return wDataOut'((s + RND) >> 16);
`endif
    endfunction

    state_t state_q, state_d;
    logic [11:0] cnt_q, cnt_d, len_q, len_d;
    logic [11:0] fft_fix, len_eff, idx;
    logic        sop_in, accept, last, eop_acc, errl_acc, errs_acc;

    logic                       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic [3:0]                 f1_q, f1_d, f2_q, f2_d, f3_q, f3_d, f4_q, f4_d;
    logic signed [wDataIn-1:0]  yr1_q, yr1_d, yi1_q, yi1_d;
    logic signed [wP-1:0]       prr_q, prr_d, pii_q, pii_d, pir_q, pir_d, pri_q, pri_d;
    logic signed [wS-1:0]       re3_q, re3_d, im3_q, im3_d;
    logic signed [wDataOut-1:0] re4_q, re4_d, im4_q, im4_d;

    // The SOP sample is index 0 of its own symbol even when it interrupts a running one.
    always_comb begin
        sop_in   = bus.sink_valid & bus.sink_sop;
        accept   = bus.sink_valid & (bus.sink_sop | (state_q == RUN));
        fft_fix  = (bus.fftpts_in == 12'd0 || bus.fftpts_in > 12'd2048) ? 12'd2048 : bus.fftpts_in;
        len_eff  = sop_in ? fft_fix : len_q;
        idx      = sop_in ? 12'd0 : cnt_q;
        last     = (idx == len_eff - 12'd1);
        eop_acc  = accept & (bus.sink_eop | last);
        errl_acc = accept & (bus.sink_eop ^ last);
        errs_acc = sop_in & (state_q == RUN);

        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (sop_in)
            len_d = fft_fix;
        if (accept) begin
            cnt_d   = idx + 12'd1;
            state_d = eop_acc ? IDLE : RUN;
        end
    end

    assign bus.rom_addr = idx[10:0];

    // Data registers only load with a valid sample so outputs hold across gaps.
    always_comb begin
        v1_d  = accept;
        f1_d  = accept ? {sop_in, eop_acc, errl_acc, errs_acc} : 4'b0;
        yr1_d = accept ? bus.sink_real : yr1_q;
        yi1_d = accept ? bus.sink_imag : yi1_q;

        v2_d  = v1_q;
        f2_d  = f1_q;
        prr_d = v1_q ? wP'(yr1_q) * wP'(bus.rom_real) : prr_q;
        pii_d = v1_q ? wP'(yi1_q) * wP'(bus.rom_imag) : pii_q;
        pir_d = v1_q ? wP'(yi1_q) * wP'(bus.rom_real) : pir_q;
        pri_d = v1_q ? wP'(yr1_q) * wP'(bus.rom_imag) : pri_q;

        v3_d  = v2_q;
        f3_d  = f2_q;
        re3_d = v2_q ? wS'(prr_q) + wS'(pii_q) : re3_q;
        im3_d = v2_q ? wS'(pir_q) - wS'(pri_q) : im3_q;

        v4_d  = v3_q;
        f4_d  = f3_q;
        re4_d = v3_q ? fit(re3_q) : re4_q;
        im4_d = v3_q ? fit(im3_q) : im4_q;
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            v4_q    <= 1'b0;
            f1_q    <= '0;
            f2_q    <= '0;
            f3_q    <= '0;
            f4_q    <= '0;
            yr1_q   <= '0;
            yi1_q   <= '0;
            prr_q   <= '0;
            pii_q   <= '0;
            pir_q   <= '0;
            pri_q   <= '0;
            re3_q   <= '0;
            im3_q   <= '0;
            re4_q   <= '0;
            im4_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            v4_q    <= v4_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            f3_q    <= f3_d;
            f4_q    <= f4_d;
            yr1_q   <= yr1_d;
            yi1_q   <= yi1_d;
            prr_q   <= prr_d;
            pii_q   <= pii_d;
            pir_q   <= pir_d;
            pri_q   <= pri_d;
            re3_q   <= re3_d;
            im3_q   <= im3_d;
            re4_q   <= re4_d;
            im4_q   <= im4_d;
        end
    end

    assign bus.source_valid = v4_q;
    assign bus.source_sop   = f4_q[3];
    assign bus.source_eop   = f4_q[2];
    assign bus.err_len      = f4_q[1];
    assign bus.err_sop      = f4_q[0];
    assign bus.source_real  = re4_q;
    assign bus.source_imag  = im4_q;
endmodule

// File: tb/tb_ce_ls_rs_rx.sv
// tb/tb_ce_ls_rs_rx.sv - randomized self-checking bench for ce_ls_rs_rx against a symbol-level model
`timescale 1ns/1ps
module tb_ce_ls_rs_rx;
    localparam int WI = 18;
    localparam int WO = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ce_ls_rs_rx_if #(.wDataIn(WI), .wDataOut(WO)) bus ();
    ce_ls_rs_rx #(.wDataIn(WI), .wDataOut(WO)) dut (.clk(clk), .rst_n_sync(rst_n), .bus(bus));

    logic signed [17:0] rom_re [0:2047];
    logic signed [17:0] rom_im [0:2047];
    always @(posedge clk) begin
        bus.rom_real <= rom_re[bus.rom_addr];
        bus.rom_imag <= rom_im[bus.rom_addr];
    end

    int n_chk = 0;
    int n_err = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [35:0] data;
        logic [3:0]  flags;
        int          cyc;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;
    bit   m_run = 0;
    int   m_idx = 0;
    int   m_len = 0;

    function automatic logic [17:0] fit(input longint v);
        longint h;
        h = (v + 32768) >>> 16;
`ifdef CE_LS_RS_RX_SAT_EN
        if (h > 131071) h = 131071;
        else if (h < -131072) h = -131072;
`endif
        return h[17:0];
    endfunction

    // Symbol-level reference: H[k] = Y[k]*conj(X[k]) rounded, with the framing rules.
    task automatic model(input bit v, input bit sop, input bit eop,
                         input logic signed [17:0] yr, input logic signed [17:0] yi,
                         input logic [11:0] fft);
        exp_t   e;
        bit     last, errs;
        longint a, b, c, d;
        if (!v) return;
        errs = 1'b0;
        if (sop) begin
            errs  = m_run;
            m_run = 1'b1;
            m_idx = 0;
            m_len = (fft == 0 || fft > 2048) ? 2048 : int'(fft);
        end else if (!m_run) begin
            return;
        end
        last = (m_idx == m_len - 1);
        a = yr; b = yi; c = rom_re[m_idx]; d = rom_im[m_idx];
        e.data  = {fit(a * c + b * d), fit(b * c - a * d)};
        e.flags = {sop, eop | last, eop != last, errs};
        e.cyc   = cyc + 4;
        expq.push_back(e);
        if (eop | last) m_run = 1'b0;
        else m_idx++;
    endtask

    task automatic drive(input bit v, input bit sop, input bit eop,
                         input logic signed [17:0] yr, input logic signed [17:0] yi,
                         input logic [11:0] fft);
        @(posedge clk);
        #1;
        bus.sink_valid = v;
        bus.sink_sop   = sop;
        bus.sink_eop   = eop;
        bus.sink_real  = yr;
        bus.sink_imag  = yi;
        bus.fftpts_in  = sop ? fft : 12'($urandom);
        model(v, sop, eop, yr, yi, fft);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 18'($urandom), 18'($urandom), 12'd0);
    endtask

    task automatic send_sym(input int n, input logic [11:0] fft, input int eop_at, input bit loop,
                            input int gap_after, input int gap_len, input bit rnd_gap);
        for (int k = 0; k < n; k++) begin
            logic signed [17:0] yr, yi;
            yr = loop ? rom_re[k] : 18'($urandom);
            yi = loop ? rom_im[k] : 18'($urandom);
            drive(1'b1, k == 0, k == eop_at, yr, yi, fft);
            if (k == gap_after) idle(gap_len);
            if (rnd_gap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    logic [35:0] last_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = '0;
        end else if (bus.source_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = expq.pop_front();
                check("data", {bus.source_real, bus.source_imag}, mon_e.data);
                check("flags", {bus.source_sop, bus.source_eop, bus.err_len, bus.err_sop}, mon_e.flags);
                check("latency", cyc, mon_e.cyc);
            end
            last_data = {bus.source_real, bus.source_imag};
        end else begin
            check("idle_hold", {bus.source_sop, bus.source_eop, bus.err_len, bus.err_sop,
                                bus.source_real, bus.source_imag}, {4'b0, last_data});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check(tag, {bus.source_valid, bus.source_sop, bus.source_eop, bus.err_len, bus.err_sop,
                    bus.source_real, bus.source_imag}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [17:0] ur [0:7];
        logic signed [17:0] ui [0:7];
        ur = '{65536, 0, -65536, 0, 46341, 46341, -46341, -46341};
        ui = '{0, 65536, 0, -65536, 46341, -46341, 46341, -46341};
        for (int k = 0; k < 2048; k++) begin
            rom_re[k] = 18'($urandom);
            rom_im[k] = 18'($urandom);
        end
        for (int k = 0; k < 12; k++) begin
            rom_re[k] = ur[k % 8];
            rom_im[k] = ui[k % 8];
        end
        rom_re[12] = 18'sd65535;
        rom_im[12] = 18'sd65535;

        bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
        bus.sink_real = '0; bus.sink_imag = '0; bus.fftpts_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #2 rst_n = 1'b1;

        send_sym(12, 12'd12, 11, 1'b1, -1, 0, 1'b0);
        idle(3);
        send_sym(12, 12'd12, 11, 1'b1, 5, 3, 1'b0);
        idle(2);
        send_sym(9, 12'd12, 8, 1'b0, -1, 0, 1'b0);
        send_sym(12, 12'd12, 11, 1'b1, -1, 0, 1'b0);
        send_sym(6, 12'd12, -1, 1'b1, -1, 0, 1'b0);
        send_sym(12, 12'd12, 11, 1'b1, -1, 0, 1'b0);
        idle(2);

        for (int k = 0; k < 13; k++)
            drive(1'b1, k == 0, k == 12, (k == 12) ? 18'sd131071 : rom_re[k],
                  (k == 12) ? 18'sd131071 : rom_im[k], 12'd13);
        idle(2);
        send_sym(1, 12'd1, 0, 1'b0, -1, 0, 1'b0);
        send_sym(1, 12'd1, -1, 1'b0, -1, 0, 1'b0);
        send_sym(4, 12'd2, -1, 1'b0, -1, 0, 1'b0);
        send_sym(2048, 12'd0, 2047, 1'b0, -1, 0, 1'b0);
        send_sym(2050, 12'd3000, -1, 1'b0, -1, 0, 1'b0);
        idle(6);

        send_sym(5, 12'd12, -1, 1'b1, -1, 0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        bus.sink_valid = 1'b0;
        expq.delete();
        m_run = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_symbol");
        @(posedge clk); #2 rst_n = 1'b1;
        send_sym(12, 12'd12, 11, 1'b1, -1, 0, 1'b0);
        idle(2);

        for (int s = 0; s < 40; s++) begin
            int          len, mode;
            logic [11:0] fft;
            len  = $urandom_range(1, 16);
            fft  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'(len);
            mode = $urandom_range(0, 3);
            case (mode)
                0: send_sym(len, fft, len - 1, 1'b0, -1, 0, 1'b1);
                1: send_sym(len, fft, $urandom_range(0, len - 1), 1'b0, -1, 0, 1'b1);
                2: send_sym(len + 2, fft, -1, 1'b0, -1, 0, 1'b1);
                default: send_sym($urandom_range(1, len), fft, -1, 1'b0, -1, 0, 1'b1);
            endcase
            if ($urandom_range(0, 2) == 0)
                drive(1'b1, 1'b0, 1'($urandom), 18'($urandom), 18'($urandom), 12'd0);
        end
        idle(6);

        for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain", expq.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ce_ls_rs_rx.md
Name: ce_LS_RS_rx

Overview:
- Receive-side counterpart of the RS transmit sequence generator.
- Takes received frequency-domain RS samples Y[k] for one OFDM symbol and reads the same local ZC reference X[k] from ROM_RS_tx_UE0_real/imag (Q16, i.e. ×65536, 11-bit address, 1-clk read latency).
- Outputs the LS channel estimate H[k] = Y[k]·conj(X[k]) >> 16, with SOP/EOP framing and error flags, to the downstream CE interpolation stage.

Parameters:
- wDataIn, 18, width of signed sink_real/sink_imag.
- wDataOut, 18, width of signed source_real/source_imag; also the ROM data width.

Ports:
- clk  in  1  system clock
- rst_n_sync  in  1  asynchronous active-low reset
- sink_valid  in  1  input sample qualifier
- sink_sop  in  1  first sample of symbol; only meaningful with sink_valid
- sink_eop  in  1  last sample of symbol; only meaningful with sink_valid
- sink_real  in  wDataIn  received real part, signed
- sink_imag  in  wDataIn  received imaginary part, signed
- fftpts_in  in  12  number of RS subcarriers; sampled at SOP; legal 1..2048
- source_valid  out  1  estimate valid
- source_sop  out  1  first estimate of symbol
- source_eop  out  1  last estimate of symbol
- source_real  out  wDataOut  Re(H), signed
- source_imag  out  wDataOut  Im(H), signed
- err_len  out  1  one-cycle pulse on a length error
- err_sop  out  1  one-cycle pulse on SOP received mid-symbol

Behaviour:
- Reset: all outputs, pipeline registers, counter and FSM cleared to 0/IDLE asynchronously. Reset mid-symbol aborts it; nothing is emitted for that symbol.
- FSM states: IDLE, RUN.
- IDLE:
  - sink_valid&sink_sop: latch len = fftpts_in, use ROM address 0, cnt <= 1, go RUN.
  - sink_valid&sink_sop&sink_eop with len==1: single-sample symbol; stays IDLE.
  - Valid samples without SOP are discarded.
- RUN:
  - Each valid sample uses ROM address = cnt; cnt <= cnt+1.
  - sink_valid low holds cnt and state (gaps allowed; input is never backpressured).
- ROM address (11 bits) is driven combinationally: 0 on a valid SOP, else cnt[10:0]. Count 2048 is never addressed.
- Length rules, checked on each accepted sample with index i (SOP sample i=0):
  - eop at i==len-1: normal end, go IDLE.
  - eop at i!=len-1: that sample is still emitted with source_eop=1; err_len pulses with it; go IDLE.
  - i==len-1 without eop: sample emitted with source_eop=1; err_len pulses; go IDLE; later samples discarded until the next SOP.
- SOP while in RUN:
  - err_sop pulses; the old symbol is truncated with no EOP emitted.
  - The new sample is accepted as index 0 of a new symbol.
- fftpts_in of 0 or >2048 at SOP: treated as 2048.
- Datapath, fixed latency 4 cycles from accepted sink sample to source output:
  - S1: register Y and flags, aligned with the ROM q.
  - S2: four signed products Yr·Xr, Yi·Xi, Yi·Xr, Yr·Xi, each (wDataIn+wDataOut) bits.
  - S3: re = Yr·Xr + Yi·Xi; im = Yi·Xr − Yr·Xi; one guard bit.
  - S4: add 2^15, arithmetic shift right 16, then saturate/truncate to wDataOut (see Optional Feature); register outputs.
- Discarded samples produce no source_valid. source_sop/eop/err_* are only asserted together with source_valid.
- When source_valid=0, source_real/source_imag hold their last value.

Optional Feature:
- CE_LS_RS_RX_SAT_EN
- Defined: S4 result is clamped to [−2^(wDataOut−1), 2^(wDataOut−1)−1].
- Undefined: S4 keeps the low wDataOut bits (two's-complement wrap). Saves logic when input scaling guarantees headroom.

Test Plan:
- Loopback, fftpts_in=12: drive Y[k] = ROM X[k] contiguously, SOP at k=0 and EOP at k=11.
  - Expect 12 outputs starting 4 cycles after the first input, each source_real=65536±1, source_imag=0±1.
  - source_sop on output 0, source_eop on output 11, no err pulses.
- Same symbol with sink_valid low for 3 cycles after sample 5:
  - Same 12 values; output gap mirrors input; latency remains 4 per sample.
- fftpts_in=12 with EOP at sample 8: output 8 carries source_eop=1 and err_len=1; the next SOP symbol is processed normally.
- SOP reasserted at sample 6 of a 12-point symbol:
  - err_sop=1 coincides with the new symbol's output 0, which has source_sop=1.
  - The new symbol's ROM address restarts at 0.
- Saturation check: Y=(131071,131071) against a ROM entry with Xr=Xi=65535.
  - With CE_LS_RS_RX_SAT_EN: source_real=131071.
  - Without it: wrapped value equals the low 18 bits of the rounded result.
- Async reset pulse mid-symbol, then a fresh SOP symbol:
  - All outputs read 0 during reset.
  - No EOP is emitted for the aborted symbol; the new symbol is correct.
